// File: rtl/sample_delay_align_if.sv
// Stream bus for sample_delay_align: qualified sample in, delay control,
// qualified delayed sample and status out.
interface sample_delay_align_if #(
  parameter int DATA_W = 25,
  parameter int AW     = 4
);
  logic signed [DATA_W-1:0] data_in;
  logic                     in_valid;
  logic [AW:0]              delay_cfg;
  logic                     delay_load;
  logic signed [DATA_W-1:0] data_out;
  logic                     out_valid;
  logic                     primed;
  logic [AW:0]              delay_cur;

  modport master (
    output data_in, in_valid, delay_cfg, delay_load,
    input  data_out, out_valid, primed, delay_cur
  );

  modport slave (
    input  data_in, in_valid, delay_cfg, delay_load,
    output data_out, out_valid, primed, delay_cur
  );
endinterface

// File: rtl/sample_delay_align.sv
// Sample-count delay line: circular buffer whose read tap trails the write
// pointer by delay_cur valid samples, so gapped streams stay aligned.
module sample_delay_align #(
  parameter int DATA_W        = 25,
  parameter int MAX_DELAY     = 16,
  parameter int AW            = 4,
  parameter int DEFAULT_DELAY = 3
) (
  input  logic               clk,
  input  logic               reset,
  sample_delay_align_if.slave bus
);
  localparam logic [AW:0] MAXD = (AW+1)'(MAX_DELAY);
  localparam logic [AW:0] DEFD = (AW+1)'(DEFAULT_DELAY);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic signed [DATA_W-1:0] mem [MAX_DELAY];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_addr;
  logic [AW:0]              fill_cnt;
  logic [AW:0]              fill_nxt;
  logic [AW:0]              delay_nxt;
  logic [AW:0]              cfg_clamped;
  logic                     rd_en;

  always_comb begin
    cfg_clamped = bus.delay_cfg;
    if (bus.delay_cfg == '0)       cfg_clamped = ONE;
    else if (bus.delay_cfg > MAXD) cfg_clamped = MAXD;
  end

  // Low AW bits of MAX_DELAY are zero, so a full-depth tap lands on wr_ptr
  // and returns the oldest entry before it is overwritten.
  assign rd_addr = wr_ptr - bus.delay_cur[AW-1:0];
  assign rd_en   = bus.in_valid && !bus.delay_load && (fill_cnt >= bus.delay_cur);

  always_comb begin
    fill_nxt  = fill_cnt;
    delay_nxt = bus.delay_cur;
    if (bus.delay_load) begin
      delay_nxt = cfg_clamped;
      fill_nxt  = {{AW{1'b0}}, bus.in_valid};
    end else if (bus.in_valid && fill_cnt != MAXD) begin
      fill_nxt = fill_cnt + ONE;
    end
  end

  // Storage is never cleared; the fill gate hides stale entries.
  always_ff @(posedge clk) begin
    if (bus.in_valid) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      fill_cnt      <= '0;
      bus.delay_cur <= DEFD;
      bus.data_out  <= '0;
      bus.out_valid <= 1'b0;
      bus.primed    <= 1'b0;
    end else begin
      if (bus.in_valid) wr_ptr <= wr_ptr + AW'(1);
      fill_cnt      <= fill_nxt;
      bus.delay_cur <= delay_nxt;
      bus.out_valid <= rd_en;
      if (rd_en) bus.data_out <= mem[rd_addr];
      bus.primed    <= (fill_nxt >= delay_nxt);
    end
  end
endmodule

// File: doc/sample_delay_align.md
Name: sample_delay_align

Overview:
- Programmable sample-count delay line for 25-bit signed datapath streams.
- Complements the fixed cycle-count delay registers. Delay is counted in valid input samples, not clock cycles, so gapped streams stay aligned.
- Used to re-align a qualified stream against a parallel branch of different latency.
- Circular buffer with a write pointer and a registered read tap. Depth is runtime-selectable up to MAX_DELAY.

Parameters:
DATA_W, 25, sample width (signed two's complement)
MAX_DELAY, 16, buffer depth and largest selectable delay (power of two)
AW, 4, log2(MAX_DELAY), pointer width
DEFAULT_DELAY, 3, delay applied after reset (1..MAX_DELAY)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
data_in  input  DATA_W  signed input sample
in_valid  input  1  data_in qualifier; one sample per high cycle
delay_cfg  input  AW+1  requested delay in samples
delay_load  input  1  one-cycle pulse: apply delay_cfg
data_out  output  DATA_W  signed delayed sample (registered)
out_valid  output  1  data_out qualifier (registered)
primed  output  1  high when buffer holds at least delay_cur samples
delay_cur  output  AW+1  delay currently applied

Behaviour:
- Reset: asynchronous and active-high; clock and reset ports are named clk and reset. On reset assertion:
  - wr_ptr = 0, fill_cnt = 0.
  - data_out = 0, out_valid = 0, primed = 0.
  - delay_cur = DEFAULT_DELAY.
  - Memory contents are not cleared; the priming gate makes stale contents unobservable.
  - Reset asserted mid-stream has the same effect. The first valid sample after reset release is treated as sample 0 of a fresh fill.
- Write, on a cycle with in_valid=1:
  - mem[wr_ptr] <= data_in.
  - wr_ptr <= wr_ptr+1, wrapping MAX_DELAY-1 -> 0.
  - fill_cnt <= min(fill_cnt+1, MAX_DELAY).
- Read, on a cycle with in_valid=1 and fill_cnt >= delay_cur (both evaluated before the update):
  - data_out <= mem[(wr_ptr - delay_cur) mod MAX_DELAY], using read-before-write semantics.
  - out_valid <= 1.
  - When delay_cur = MAX_DELAY the read address equals wr_ptr, so the old contents are returned.
- Any other cycle: out_valid <= 0 and data_out holds its last value.
- Net effect: the sample accepted on valid-beat n appears on data_out one clock after valid-beat n+D, where D = delay_cur.
- primed is a register equal to (fill_cnt >= delay_cur), updated every clock.
- delay_load:
  - Clamp rule: delay_cur <= delay_cfg, except 0 becomes 1 and values above MAX_DELAY become MAX_DELAY.
  - fill_cnt is flushed, so out_valid stays low until D new samples have been written.
  - wr_ptr is not reset.
  - If delay_load and in_valid occur in the same cycle: the sample is written, fill_cnt <= 1, and out_valid <= 0 that cycle.
  - delay_load is ignored while reset is asserted.
- Arithmetic: pointer subtraction is done modulo 2^AW. Data passes through bit-exact, with no sign or width change.
- in_valid low has no effect on pointers or fill; gaps of any length are allowed.
- Throughput: one sample per clock sustained, with no backpressure.

Test Plan:
- Reset, then D=3 (default) with continuous in_valid and data_in = 1,2,...,10:
  - out_valid first rises the cycle after the 4th input.
  - data_out runs 1,2,...,7 on consecutive cycles.
  - primed rises the cycle after the 3rd input.
- D=3 with in_valid toggling 1,0,1,0 and data_in = -5,-6,-7,-8,-9:
  - Delayed outputs are -5 then -6, each one cycle after the valid beats carrying -8 and -9.
  - Sign is preserved and out_valid is low on gap cycles.
- delay_cfg=16 with 40 continuous samples 100..139:
  - First out_valid follows sample 116 and carries 100.
  - Outputs stay contiguous across pointer wrap, with last output 123.
- Mid-stream delay_load=5 coincident with sample 20 while running D=2:
  - out_valid drops that cycle and stays low for the next 4 samples.
  - The next output carries 20, one cycle after sample 25 is accepted.
- Clamp: delay_cfg=0 -> delay_cur=1; delay_cfg=20 -> delay_cur=16. Each is checked via delay_cur and via first-output timing.
- Assert reset asynchronously (mid-cycle) during steady D=4 flow:
  - data_out=0, out_valid=0, primed=0 and delay_cur=3 immediately, without waiting for a clock edge.
  - After release, the first output carries the 1st post-reset sample.
